// File: rtl/cache_assoc_if.sv
// Command/response bundle between the memory-system controller and the
// set-associative cache array. The controller holds the master modport.
interface cache_assoc_if #(
   parameter int TAG_W  = 5,
   parameter int IDX_W  = 8,
   parameter int DATA_W = 16,
   parameter int OFF_W  = 3,
   parameter int WAYS   = 2
);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic              enable;
   logic              comp;
   logic              write;
   logic              valid_in;
   logic [TAG_W-1:0]  tag_in;
   logic [IDX_W-1:0]  index;
   logic [OFF_W-1:0]  offset;
   logic [DATA_W-1:0] data_in;
   logic [WAY_W-1:0]  way_sel;
   logic              flush;
   logic              createdump;
   logic [TAG_W-1:0]  tag_out;
   logic [DATA_W-1:0] data_out;
   logic              hit;
   logic              dirty;
   logic              valid;
   logic              err;
   logic [WAY_W-1:0]  victim_way;
   logic              busy;
   logic [15:0]       hit_count;
   logic [15:0]       miss_count;

   modport master (
      output enable, comp, write, valid_in, tag_in, index, offset, data_in,
             way_sel, flush, createdump,
      input  tag_out, data_out, hit, dirty, valid, err, victim_way, busy,
             hit_count, miss_count
   );

   modport slave (
      input  enable, comp, write, valid_in, tag_in, index, offset, data_in,
             way_sel, flush, createdump,
      output tag_out, data_out, hit, dirty, valid, err, victim_way, busy,
             hit_count, miss_count
   );
endinterface

// File: rtl/cache_assoc.sv
// N-way set-associative cache array with tree pseudo-LRU replacement and a
// one-set-per-cycle flush sweep. Reads are combinational, writes on the
// rising edge. Optional hit/miss statistics are built when CACHE_STATS_EN
// is defined; otherwise hit_count/miss_count are tied to zero.
module cache_assoc #(
   parameter int TAG_W    = 5,
   parameter int IDX_W    = 8,
   parameter int DATA_W   = 16,
   parameter int OFF_W    = 3,
   parameter int WAYS     = 2,
   parameter int cache_id = 0
) (
   input logic           clk,
   input logic           rst_n,
   cache_assoc_if.slave  bus
);
   localparam int SETS   = 1 << IDX_W;
   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int WORD_W = OFF_W - BYTE_W;
   localparam int WORDS  = 1 << WORD_W;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

   typedef enum logic {IDLE, SWEEP} state_t;

   // Storage: tag/data are not reset, status bits are.
   logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
   logic [DATA_W-1:0] data_mem [WAYS][SETS*WORDS];
   logic [WAYS-1:0][SETS-1:0]   valid_q;
   logic [WAYS-1:0][SETS-1:0]   dirty_q;
   logic [SETS-1:0][PLRU_W-1:0] plru_q;

   state_t            state_q;
   logic [IDX_W-1:0]  set_cnt_q;
   logic              busy_q;

   logic                    go;
   logic [WORD_W-1:0]       word_idx;
   logic [IDX_W+WORD_W-1:0] line_addr;
   logic [WAYS-1:0]         match;
   logic                    any_match;
   logic [WAY_W-1:0]        hit_way;
   logic [WAY_W-1:0]        inv_way;
   logic                    any_inv;
   logic [PLRU_W-1:0]       plru_cur;
   logic [PLRU_W-1:0]       plru_upd;
   logic [WAY_W-1:0]        plru_vic;
   logic [WAY_W-1:0]        victim;
   logic [WAY_W-1:0]        sel;
   logic                    fill;
   logic                    wr_hit;
   logic                    plru_touch;
   logic                    unused_ok;

   // Holding reset also forces the command path idle so outputs read zero.
   assign go        = bus.enable & ~busy_q & rst_n;
   assign word_idx  = bus.offset[OFF_W-1:BYTE_W];
   assign line_addr = {bus.index, word_idx};
   assign unused_ok = ^{bus.createdump, 32'(cache_id)};

   generate
      if (BYTE_W > 0) begin : g_err
         assign bus.err = |bus.offset[BYTE_W-1:0];
      end else begin : g_noerr
         assign bus.err = 1'b0;
      end
   endgenerate

   // A tag match only counts when the line is valid.
   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
         assign match[gi] = valid_q[gi][bus.index] &
                            (tag_mem[gi][bus.index] == bus.tag_in);
      end
   endgenerate
   assign any_match = |match;

   // Lowest-numbered hitting way and lowest-numbered invalid way.
   always_comb begin
      hit_way = '0;
      inv_way = '0;
      any_inv = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) hit_way = WAY_W'(w);
         if (!valid_q[w][bus.index]) begin
            inv_way = WAY_W'(w);
            any_inv = 1'b1;
         end
      end
   end

   assign plru_cur = plru_q[bus.index];

   // PLRU bits point away from the most recently used way.
   generate
      if (WAYS == 2) begin : g_plru2
         assign plru_vic = plru_cur[0];
         assign plru_upd = ~sel[0];
      end else if (WAYS == 4) begin : g_plru4
         assign plru_vic = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
         // Root chooses the half, the leaf of the touched half chooses the way.
         always_comb begin
            plru_upd    = plru_cur;
            plru_upd[0] = ~sel[1];
            if (sel[1]) plru_upd[2] = ~sel[0];
            else        plru_upd[1] = ~sel[0];
         end
      end else begin : g_plru1
         assign plru_vic = '0;
         assign plru_upd = '0;
      end
   endgenerate

   assign victim     = any_inv ? inv_way : plru_vic;
   assign sel        = bus.comp ? (any_match ? hit_way : victim) : bus.way_sel;
   assign fill       = go & ~bus.comp & bus.write;
   assign wr_hit     = go & bus.comp & bus.write & any_match;
   assign plru_touch = (go & bus.comp & any_match) | fill;

   assign bus.hit        = go & bus.comp & any_match;
   assign bus.tag_out    = busy_q ? '0 : tag_mem[sel][bus.index];
   assign bus.data_out   = (go & ~bus.write) ? data_mem[sel][line_addr] : '0;
   assign bus.valid      = go & valid_q[sel][bus.index] & (~bus.write | bus.comp);
   assign bus.dirty      = go & (~bus.write | (bus.comp & ~any_match)) &
                           dirty_q[sel][bus.index];
   assign bus.victim_way = busy_q ? '0 : victim;
   assign bus.busy       = busy_q;

   // Tag and data array writes: fills load tag+word, write hits load the word.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[bus.way_sel][bus.index]  <= bus.tag_in;
         data_mem[bus.way_sel][line_addr] <= bus.data_in;
      end else if (wr_hit) begin
         data_mem[hit_way][line_addr] <= bus.data_in;
      end
   end

   // Flush sequencer plus valid/dirty/PLRU status updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         set_cnt_q <= '0;
         busy_q    <= 1'b0;
         valid_q   <= '0;
         dirty_q   <= '0;
         plru_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.flush) begin
                  state_q   <= SWEEP;
                  busy_q    <= 1'b1;
                  set_cnt_q <= '0;
               end
            end
            SWEEP: begin
               for (int w = 0; w < WAYS; w++) begin
                  valid_q[w][set_cnt_q] <= 1'b0;
                  dirty_q[w][set_cnt_q] <= 1'b0;
               end
               plru_q[set_cnt_q] <= '0;
               set_cnt_q         <= set_cnt_q + 1'b1;
               if (&set_cnt_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Commands only run while not sweeping, so these never collide.
         if (fill) begin
            valid_q[bus.way_sel][bus.index] <= bus.valid_in;
            dirty_q[bus.way_sel][bus.index] <= 1'b0;
         end
         if (wr_hit) dirty_q[hit_way][bus.index] <= 1'b1;
         if (plru_touch) plru_q[bus.index] <= plru_upd;
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;

   // Saturating hit/miss counters for compare commands; flush leaves them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (go & bus.comp) begin
         if (any_match) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
         end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
         end
      end
   end

   assign bus.hit_count  = hit_cnt_q;
   assign bus.miss_count = miss_cnt_q;
`else
   assign bus.hit_count  = '0;
   assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc (2-way, 256 sets, 16-bit words, 4 words/line).
module tb_cache_assoc;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_assoc_if #(.TAG_W(5), .IDX_W(8), .DATA_W(16), .OFF_W(3), .WAYS(2)) bus ();

   cache_assoc #(.TAG_W(5), .IDX_W(8), .DATA_W(16), .OFF_W(3), .WAYS(2), .cache_id(0))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        en, comp, wr, vin, ws;
      logic [4:0]  tag;
      logic [2:0]  off;
      logic [15:0] din;
      logic        e_hit, e_valid, e_dirty, e_err, e_vic, chk_tag;
      logic [4:0]  e_tag;
      logic [15:0] e_data;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic en, input logic comp, input logic wr, input logic vin,
                        input logic ws, input logic [4:0] tag, input logic [7:0] idx,
                        input logic [2:0] off, input logic [15:0] din, input logic fl);
      bus.enable = en;  bus.comp = comp; bus.write = wr; bus.valid_in = vin;
      bus.way_sel = ws; bus.tag_in = tag; bus.index = idx; bus.offset = off;
      bus.data_in = din; bus.flush = fl; bus.createdump = 1'b0;
   endtask

   function automatic vec_t mk(input logic en, comp, wr, vin, ws, input logic [4:0] tag,
                               input logic [2:0] off, input logic [15:0] din,
                               input logic e_hit, e_valid, e_dirty, e_err, e_vic, chk_tag,
                               input logic [4:0] e_tag, input logic [15:0] e_data);
      vec_t v;
      v.en = en; v.comp = comp; v.wr = wr; v.vin = vin; v.ws = ws; v.tag = tag;
      v.off = off; v.din = din; v.e_hit = e_hit; v.e_valid = e_valid;
      v.e_dirty = e_dirty; v.e_err = e_err; v.e_vic = e_vic; v.chk_tag = chk_tag;
      v.e_tag = e_tag; v.e_data = e_data;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      logic first_busy;

      // All on index 8'h05. Columns: en comp wr vin ws tag off din | hit valid dirty err vic chk tag data
      vecs[0]  = mk(1,1,0,0,0, 5'h03, 3'h2, 16'h0000, 0,0,0,0,0, 0, 5'h00, 16'h0000);
      vecs[1]  = mk(1,0,1,1,0, 5'h03, 3'h2, 16'hBEEF, 0,0,0,0,0, 0, 5'h00, 16'h0000);
      vecs[2]  = mk(1,0,1,1,1, 5'h07, 3'h2, 16'hBEEF, 0,0,0,0,1, 0, 5'h00, 16'h0000);
      vecs[3]  = mk(1,1,0,0,0, 5'h07, 3'h2, 16'h0000, 1,1,0,0,0, 1, 5'h07, 16'hBEEF);
      vecs[4]  = mk(1,1,0,0,0, 5'h03, 3'h2, 16'h0000, 1,1,0,0,0, 1, 5'h03, 16'hBEEF);
      vecs[5]  = mk(1,1,0,0,0, 5'h07, 3'h2, 16'h0000, 1,1,0,0,1, 1, 5'h07, 16'hBEEF);
      vecs[6]  = mk(1,1,1,0,0, 5'h03, 3'h4, 16'h1234, 1,1,0,0,0, 1, 5'h03, 16'h0000);
      vecs[7]  = mk(1,1,1,0,0, 5'h09, 3'h4, 16'h5555, 0,1,0,0,1, 1, 5'h07, 16'h0000);
      vecs[8]  = mk(1,1,0,0,0, 5'h03, 3'h4, 16'h0000, 1,1,1,0,1, 1, 5'h03, 16'h1234);
      vecs[9]  = mk(1,1,0,0,0, 5'h03, 3'h3, 16'h0000, 1,1,1,1,1, 1, 5'h03, 16'hBEEF);
      vecs[10] = mk(1,1,1,0,0, 5'h03, 3'h6, 16'hA5A5, 1,1,0,0,1, 1, 5'h03, 16'h0000);
      vecs[11] = mk(1,1,0,0,0, 5'h03, 3'h6, 16'h0000, 1,1,1,0,1, 1, 5'h03, 16'hA5A5);
      vecs[12] = mk(1,0,0,0,1, 5'h00, 3'h2, 16'h0000, 0,1,0,0,1, 1, 5'h07, 16'hBEEF);
      vecs[13] = mk(0,1,0,0,0, 5'h07, 3'h2, 16'h0000, 0,0,0,0,1, 0, 5'h00, 16'h0000);
      vecs[14] = mk(1,0,1,0,1, 5'h07, 3'h2, 16'h0000, 0,0,0,0,1, 1, 5'h07, 16'h0000);
      vecs[15] = mk(1,1,0,0,0, 5'h07, 3'h2, 16'h0000, 0,0,0,0,1, 1, 5'h07, 16'h0000);

      // Reset state, with an enabled compare read held during reset.
      rst_n = 1'b0;
      drive(1,1,0,0,0, 5'h03, 8'h05, 3'h2, 16'h0, 0);
      #2;
      check("rst_hit",    bus.hit, 0);
      check("rst_valid",  bus.valid, 0);
      check("rst_dirty",  bus.dirty, 0);
      check("rst_data",   bus.data_out, 0);
      check("rst_busy",   bus.busy, 0);
      check("rst_victim", bus.victim_way, 0);
      check("rst_hitcnt", bus.hit_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven command sequence.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].en, vecs[i].comp, vecs[i].wr, vecs[i].vin, vecs[i].ws,
               vecs[i].tag, 8'h05, vecs[i].off, vecs[i].din, 0);
         #1;
         check($sformatf("v%0d_hit", i),    bus.hit,        vecs[i].e_hit);
         check($sformatf("v%0d_valid", i),  bus.valid,      vecs[i].e_valid);
         check($sformatf("v%0d_dirty", i),  bus.dirty,      vecs[i].e_dirty);
         check($sformatf("v%0d_err", i),    bus.err,        vecs[i].e_err);
         check($sformatf("v%0d_victim", i), bus.victim_way, vecs[i].e_vic);
         check($sformatf("v%0d_data", i),   bus.data_out,   vecs[i].e_data);
         if (vecs[i].chk_tag) check($sformatf("v%0d_tag", i), bus.tag_out, vecs[i].e_tag);
         $display("vec %0d: hit=%b valid=%b dirty=%b err=%b victim=%0d tag=%h data=%h",
                  i, bus.hit, bus.valid, bus.dirty, bus.err, bus.victim_way,
                  bus.tag_out, bus.data_out);
      end

      // Flush pulse together with a compare read: the read still executes.
      @(negedge clk);
      drive(1,1,0,0,0, 5'h03, 8'h05, 3'h4, 16'h0, 1);
      #1;
      check("flushcmd_hit",  bus.hit, 1);
      check("flushcmd_data", bus.data_out, 16'h1234);
      check("flushcmd_busy", bus.busy, 0);
      busy_cycles = 0;
      first_busy  = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (c == 10)      drive(1,1,0,0,0, 5'h03, 8'h05, 3'h4, 16'h0, 0);
         else if (c == 20) drive(0,0,0,0,0, 5'h00, 8'h05, 3'h0, 16'h0, 1);
         else              drive(0,0,0,0,0, 5'h00, 8'h05, 3'h0, 16'h0, 0);
         #1;
         if (c == 0) first_busy = bus.busy;
         if (c == 10) begin
            check("busy_hit",   bus.hit, 0);
            check("busy_valid", bus.valid, 0);
            check("busy_dirty", bus.dirty, 0);
            check("busy_data",  bus.data_out, 0);
         end
         if (bus.busy) busy_cycles++;
         else break;
      end
      check("busy_rise", first_busy, 1);
      check("busy_len", busy_cycles, 256);
      $display("flush: busy for %0d cycles", busy_cycles);

      @(negedge clk);
      drive(1,1,0,0,0, 5'h03, 8'h05, 3'h4, 16'h0, 0);
      #1;
      check("postflush_hit",    bus.hit, 0);
      check("postflush_valid",  bus.valid, 0);
      check("postflush_victim", bus.victim_way, 0);
      @(negedge clk);
      drive(0,0,0,0,0, 5'h00, 8'h05, 3'h0, 16'h0, 0);
      #1;
`ifdef CACHE_STATS_EN
      check("stats_hits",   bus.hit_count, 9);
      check("stats_misses", bus.miss_count, 4);
`else
      check("stats_hits_off",   bus.hit_count, 0);
      check("stats_misses_off", bus.miss_count, 0);
`endif

      // Reset 100 cycles into a sweep aborts it at once.
      @(negedge clk);
      drive(0,0,0,0,0, 5'h00, 8'h05, 3'h0, 16'h0, 1);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         drive(0,0,0,0,0, 5'h00, 8'h05, 3'h0, 16'h0, 0);
      end
      #1;
      check("sweep100_busy", bus.busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_stay_idle", bus.busy, 0);
      check("abort_hitcnt", bus.hit_count, 0);
      $display("reset mid-sweep: busy=%b", bus.busy);

      // Boundary set 8'hFF, highest tag: fill then hit.
      @(negedge clk);
      drive(1,0,1,1,0, 5'h1F, 8'hFF, 3'h6, 16'h0F0F, 0);
      @(negedge clk);
      drive(1,1,0,0,0, 5'h1F, 8'hFF, 3'h6, 16'h0, 0);
      #1;
      check("set255_hit",  bus.hit, 1);
      check("set255_data", bus.data_out, 16'h0F0F);
      check("set255_busy", bus.busy, 0);

`ifdef CACHE_STATS_EN
      // Saturation: preload just below the top, then two more hits.
      @(negedge clk);
      dut.hit_cnt_q = 16'hFFFE;
      drive(1,1,0,0,0, 5'h1F, 8'hFF, 3'h6, 16'h0, 0);
      @(negedge clk);
      drive(1,1,0,0,0, 5'h1F, 8'hFF, 3'h6, 16'h0, 0);
      @(negedge clk);
      drive(0,0,0,0,0, 5'h00, 8'h00, 3'h0, 16'h0, 0);
      #1;
      check("stats_sat", bus.hit_count, 16'hFFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised N-way set-associative cache array. It is the successor of the 4-word direct-mapped cache array.
- Keeps the same enable/comp/write/valid_in command semantics, and adds:
  - configurable tag, index, line and word widths and way count;
  - tree pseudo-LRU victim selection;
  - a multi-cycle flush (invalidate-all) sequencer.
- Sits between the memory-system controller FSM and the four-bank main memory. The controller drives one command per cycle.

Parameters:
- TAG_W, 5, tag width.
- IDX_W, 8, index width; sets = 2^IDX_W.
- DATA_W, 16, word width; a multiple of 8 and a power of 2.
- OFF_W, 3, byte-offset width; words/line = 2^OFF_W / (DATA_W/8).
- WAYS, 2, associativity; legal values 1, 2, 4.
- cache_id, 0, instance id used for unique dump file names.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  command valid this cycle.
- comp  in  1  1 = compare (tag lookup); 0 = direct access to way_sel.
- write  in  1  1 = write command.
- valid_in  in  1  valid bit written on a fill (comp=0, write=1).
- tag_in  in  TAG_W  request tag.
- index  in  IDX_W  set index.
- offset  in  OFF_W  byte offset within the line.
- data_in  in  DATA_W  write data.
- way_sel  in  max(1,log2 WAYS)  target way when comp=0.
- flush  in  1  one-cycle pulse; starts an invalidate-all sweep.
- createdump  in  1  dump array contents to files.
- tag_out  out  TAG_W  tag of the selected way.
- data_out  out  DATA_W  read word of the selected way.
- hit  out  1  valid tag match in some way.
- dirty  out  1  dirty bit of the selected way.
- valid  out  1  valid bit of the selected way.
- err  out  1  misaligned offset.
- victim_way  out  max(1,log2 WAYS)  way to replace at this index.
- busy  out  1  flush in progress.
- hit_count  out  16  hit counter (optional feature).
- miss_count  out  16  miss counter (optional feature).

Behaviour:
- Internal signal go = enable & ~busy.
- Reads are combinational from the arrays. Writes occur on the rising clk edge when go=1.
- err = OR of offset[log2(DATA_W/8)-1:0]. It is independent of go. A command with err=1 still executes: the low offset bits are ignored.
- Way selection, sel:
  - comp=1: the hitting way if any, else victim_way.
  - comp=0: way_sel.
- hit = go & comp & OR over ways (valid[w] & tag[w]==tag_in). A tag match on an invalid line is not a hit.
- tag_out: tag of sel.
- data_out:
  - 0 when write=1 or go=0;
  - otherwise the word at offset[OFF_W-1:log2(DATA_W/8)] of sel.
- valid = go & validbit[sel] & (~write | comp).
- dirty = go & (~write | (comp & ~hit)) & dirtybit[sel].
  - A comp=1 write miss therefore reports the victim's valid, dirty and tag for writeback.
- Compare write (comp=1, write=1):
  - on hit: write the word into the hit way and set its dirty bit;
  - on miss: no state change.
- Fill (comp=0, write=1): in way_sel, write the word and the tag, set valid=valid_in, and clear dirty.
- Direct read (comp=0, write=0): no state change.
- PLRU update, at the same edge as the access:
  - triggers on a comp=1 hit (read or write) and on a fill;
  - the accessed way becomes MRU;
  - WAYS=2 uses 1 bit per set; WAYS=4 uses a 3-bit tree per set; WAYS=1 has no state.
- victim_way (combinational, for the current index):
  - the lowest-numbered invalid way if one exists;
  - otherwise the PLRU way.
- Flush FSM, states IDLE and SWEEP:
  - IDLE to SWEEP: on flush=1; busy rises the next cycle.
  - SWEEP: clears valid, dirty and PLRU for set counter 0..2^IDX_W-1, one set per cycle.
  - SWEEP to IDLE: after set 2^IDX_W-1; busy is high for exactly 2^IDX_W cycles.
  - flush while busy is ignored.
  - A flush in the same cycle as a command: the command executes, and the sweep starts next cycle.
  - Commands while busy are ignored, and all status outputs read 0.
- Reset (asynchronous, rst_n low):
  - clears all valid, dirty and PLRU bits, the flush FSM (to IDLE), the set counter and the counters;
  - tag and data arrays are not reset;
  - reset mid-sweep aborts it, busy=0 immediately.
- Output values during reset: hit=0, valid=0, dirty=0, data_out=0, busy=0, victim_way=0. tag_out follows the unreset tag array.
- Same-cycle read and write to one location: data_out=0 because write=1, and the new data is visible the next cycle.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - hit_count increments on each go & comp=1 cycle with hit=1;
  - miss_count increments on each go & comp=1 cycle with hit=0;
  - both are 16-bit and saturate at 16'hFFFF;
  - both are cleared by reset only; flush does not clear them.
- Undefined: hit_count and miss_count are tied to 0 and no counter logic is present.

Test Plan:
1. Reset; comp=1 read of index 8'h05, tag 5'h03 -> hit=0, valid=0, victim_way=0.
2. Fill way0 and way1 of index 8'h05 with tags 5'h03 and 5'h07 and data 16'hBEEF at offset 3'h2 in each; compare read of tag 5'h07 at offset 3'h2 -> hit=1, data_out=16'hBEEF, valid=1, dirty=0, victim_way=0 next cycle.
3. Compare write of 16'h1234 to tag 5'h03 at offset 3'h4 -> dirty set in way0. Compare write of tag 5'h09 -> hit=0, valid=1, tag_out=5'h07, dirty=0. Compare read of tag 5'h03 -> victim_way=1.
4. Offset 3'h3 on any command -> err=1. Offset 3'h6 -> err=0 and word 3 is selected.
5. Pulse flush -> busy=1 for 256 cycles. An enable'd compare read during this window -> all outputs 0. After busy falls, index 8'h05 -> valid=0, hit=0. Assert rst_n low at sweep cycle 100 -> busy=0 immediately.
6. With CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2. Preload 16'hFFFF, then one more hit -> hit_count stays 16'hFFFF.
